// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package mem_access_unit_pkg;

    // Store size code carried from ID in the mem_write control field.
    typedef enum logic [1:0] {
        WRITE_IDLE = 2'b00,
        WRITE_BYTE = 2'b01,
        WRITE_HALF = 2'b10,
        WRITE_WORD = 2'b11
    } write_size_e;

    // Load funct3 codes; any other value behaves as LW.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REQ      = 2'b01,
        ST_WAIT_RSP = 2'b10,
        ST_DONE     = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] byte_enables(acc_size_e sz, logic [1:0] off);
        case (sz)
            SZ_BYTE: byte_enables = 4'b0001 << off;
            SZ_HALF: byte_enables = 4'b0011 << {off[1], 1'b0};
            default: byte_enables = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection followed by extension according to the load type.
    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
            F3_LBU:  ext_data = {24'h0, sel_byte};
            F3_LHU:  ext_data = {16'h0, sel_half};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: launches one data-memory transaction per
// instruction, stalls the pipeline until it completes, extends load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic [1:0]        mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              misalign
);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] load_data_q;

    logic              is_store, op, aligned, launch, capture;
    acc_size_e         size;
    logic [DATA_W-1:0] wdata_rep;
    logic [31:0]       ext_data;

    // Decode the incoming instruction: size, alignment and replicated store data.
    always_comb begin
        is_store = (mem_write != WRITE_IDLE);
        op       = is_store | mem_read;
        if (is_store) begin
            case (mem_write)
                WRITE_BYTE: size = SZ_BYTE;
                WRITE_HALF: size = SZ_HALF;
                default:    size = SZ_WORD;
            endcase
        end else begin
            case (funct3[1:0])
                2'b00:   size = SZ_BYTE;
                2'b01:   size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end
        case (size)
            SZ_HALF: aligned = ~addr[0];
            SZ_WORD: aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (size)
            SZ_BYTE: wdata_rep = {4{store_data[7:0]}};
            SZ_HALF: wdata_rep = {2{store_data[15:0]}};
            default: wdata_rep = store_data;
        endcase
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_d        = state_q;
        launch         = 1'b0;
        capture        = 1'b0;
        dmem_req_valid = 1'b0;
        lsu_busy       = 1'b0;
        lsu_done       = 1'b0;
        misalign       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (aligned) begin
                        launch   = 1'b1;
                        lsu_busy = 1'b1;
                        state_d  = ST_REQ;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                dmem_req_valid = 1'b1;
                lsu_busy       = 1'b1;
                if (dmem_req_ready) state_d = we_q ? ST_DONE : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                lsu_busy = 1'b1;
                if (dmem_rsp_valid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                lsu_done = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Request latch at launch and load result capture on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            load_data_q <= '0;
        end else begin
            if (launch) begin
                we_q     <= is_store;
                addr_q   <= {addr[ADDR_W-1:2], 2'b00};
                be_q     <= byte_enables(size, addr[1:0]);
                wdata_q  <= wdata_rep;
                funct3_q <= funct3;
                off_q    <= addr[1:0];
            end
            if (capture) load_data_q <= ext_data;
        end
    end

    load_extend u_load_extend (
        .rdata    (dmem_rdata),
        .byte_off (off_q),
        .funct3   (funct3_q),
        .ext_data (ext_data)
    );

    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level driver that
// knows the expected cycle-by-cycle behaviour, checked on every negedge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid, lsu_busy, lsu_done, misalign;

    int checks = 0;
    int failures = 0;

    // Expected values maintained by the driver.
    logic        chk_en = 1'b0;
    logic        exp_valid, exp_busy, exp_done, exp_mis, exp_we, exp_chk_wdata, exp_rstv;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_be;

    // Last accepted request, for literal checks of directed cases.
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .load_data      (load_data),
        .lsu_busy       (lsu_busy),
        .lsu_done       (lsu_done),
        .misalign       (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: access width in bytes.
    function automatic int unsigned acc_bytes(input bit is_st, input logic [1:0] mw,
                                              input logic [2:0] f3);
        int unsigned sel;
        sel = is_st ? int'(mw) - 1 : int'(f3[1:0]);
        if (sel == 0) return 1;
        if (sel == 1) return 2;
        return 4;
    endfunction

    // Reference: load result from the addressed bytes of the read word.
    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] w;
        w = rd >> (int'(off) * 8);
        case (f3)
            3'b000:  return 32'($signed(w[7:0]));
            3'b001:  return 32'($signed(w[15:0]));
            3'b100:  return w & 32'hFF;
            3'b101:  return w & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
    endtask

    task automatic clear_op();
        mem_read = 1'b0; mem_write = 2'b00;
    endtask

    // One instruction from issue to completion (or misalign rejection).
    task automatic do_op(input bit is_st, input logic [1:0] mw, input logic mr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input int unsigned rdly, input int unsigned pdly,
                         input logic [31:0] rd);
        int unsigned n;
        n = acc_bytes(is_st, mw, f3);
        mem_write  = is_st ? mw : 2'b00;
        mem_read   = is_st ? mr : 1'b1;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        dmem_req_ready = 1'($urandom);
        dmem_rsp_valid = 1'($urandom);
        dmem_rdata     = $urandom;
        exp_idle();
        if (a % n != 0) begin
            exp_mis = 1'b1;
            step();
            clear_op();
            exp_idle();
            return;
        end
        exp_busy = 1'b1;
        step();
        exp_valid     = 1'b1;
        exp_we        = is_st;
        exp_addr      = a & 32'hFFFF_FFFC;
        exp_be        = (n == 4) ? 4'hF : 4'((n == 1 ? 1 : 3) << (a % 4));
        exp_chk_wdata = is_st;
        exp_wdata     = (n == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                        (n == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        for (int unsigned i = 0; i <= rdly; i++) begin
            dmem_req_ready = (i == rdly);
            dmem_rsp_valid = 1'($urandom);
            step();
        end
        exp_valid = 1'b0;
        if (!is_st) begin
            for (int unsigned i = 0; i <= pdly; i++) begin
                dmem_req_ready = 1'($urandom);
                dmem_rsp_valid = (i == pdly);
                dmem_rdata     = (i == pdly) ? rd : $urandom;
                step();
            end
            exp_ld = ref_load(rd, a[1:0], f3);
        end
        // Completion cycle: inputs still present the same instruction.
        exp_busy = 1'b0;
        exp_done = 1'b1;
        dmem_rsp_valid = 1'($urandom);
        dmem_rdata     = $urandom;
        step();
        clear_op();
        exp_idle();
    endtask

    task automatic idle_cycles(input int unsigned k);
        for (int unsigned i = 0; i < k; i++) begin
            dmem_req_ready = 1'($urandom);
            dmem_rsp_valid = 1'($urandom);
            dmem_rdata     = $urandom;
            step();
        end
    endtask

    // Per-cycle comparison against the expected values.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_valid", 32'(dmem_req_valid), 32'(exp_valid));
            chk("busy", 32'(lsu_busy), 32'(exp_busy));
            chk("done", 32'(lsu_done), 32'(exp_done));
            chk("misalign", 32'(misalign), 32'(exp_mis));
            chk("load_data", load_data, exp_ld);
            if (exp_valid) begin
                chk("we", 32'(dmem_we), 32'(exp_we));
                chk("addr", dmem_addr, exp_addr);
                chk("be", 32'(dmem_be), 32'(exp_be));
                if (exp_chk_wdata) chk("wdata", dmem_wdata, exp_wdata);
            end
            if (exp_rstv) begin
                chk("rst_we", 32'(dmem_we), 32'h0);
                chk("rst_addr", dmem_addr, 32'h0);
                chk("rst_be", 32'(dmem_be), 32'h0);
                chk("rst_wdata", dmem_wdata, 32'h0);
            end
            if (dmem_req_valid && dmem_req_ready) begin
                last_addr  = dmem_addr;
                last_be    = dmem_be;
                last_wdata = dmem_wdata;
                last_we    = dmem_we;
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_op();
        funct3 = 3'b000; addr = '0; store_data = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        exp_idle();
        exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_chk_wdata = 1'b0;
        exp_ld = '0; exp_rstv = 1'b0;
        last_addr = '0; last_be = '0; last_wdata = '0; last_we = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        exp_rstv = 1'b1;
        dmem_req_ready = 1'b1;   // ready with no request must be harmless
        step();
        exp_rstv = 1'b0;
        dmem_req_ready = 1'b0;

        // Directed cases.
        do_op(1, 2'b11, 0, 3'b000, 32'h104, 32'hDEADBEEF, 0, 0, 0);
        @(negedge clk);
        chk("sw_addr", last_addr, 32'h104);
        chk("sw_be", 32'(last_be), 32'hF);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_we", 32'(last_we), 32'h1);
        idle_cycles(1);

        do_op(1, 2'b01, 0, 3'b000, 32'h203, 32'h0000_00A5, 3, 0, 0);
        @(negedge clk);
        chk("sb_addr", last_addr, 32'h200);
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
        idle_cycles(1);

        do_op(0, 2'b00, 1, 3'b000, 32'h101, 0, 0, 1, 32'h0000_80FF);
        @(negedge clk);
        chk("lb_lit", load_data, 32'hFFFFFF80);
        do_op(0, 2'b00, 1, 3'b100, 32'h101, 0, 1, 1, 32'h0000_80FF);
        @(negedge clk);
        chk("lbu_lit", load_data, 32'h00000080);
        do_op(0, 2'b00, 1, 3'b001, 32'h102, 0, 0, 0, 32'h8001_0000);
        @(negedge clk);
        chk("lh_lit", load_data, 32'hFFFF8001);
        do_op(0, 2'b00, 1, 3'b101, 32'h102, 0, 0, 2, 32'h8001_0000);
        @(negedge clk);
        chk("lhu_lit", load_data, 32'h00008001);

        // Misaligned accesses: pulse only, load_data unchanged.
        do_op(0, 2'b00, 1, 3'b010, 32'h106, 0, 0, 0, 0);
        do_op(1, 2'b10, 0, 3'b000, 32'h101, 32'h1234, 0, 0, 0);
        idle_cycles(2);
        chk("mis_keep_ld", load_data, 32'h00008001);

        // Reset while waiting for a load response; late response is discarded.
        mem_read = 1'b1; mem_write = 2'b00; funct3 = 3'b010; addr = 32'h300;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        exp_idle(); exp_busy = 1'b1;
        step();
        exp_valid = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF;
        exp_chk_wdata = 1'b0;
        dmem_req_ready = 1'b1;
        step();
        exp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_op();
        dmem_rsp_valid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        exp_idle(); exp_ld = '0; exp_rstv = 1'b1;
        step();
        dmem_rsp_valid = 1'b0;
        step();
        exp_rstv = 1'b0;
        chk("rst_ld_lit", load_data, 32'h0);

        // Randomized traffic.
        for (int unsigned t = 0; t < 300; t++) begin
            bit          st;
            logic [31:0] a;
            st = 1'($urandom);
            a  = $urandom;
            do_op(st, 2'($urandom_range(1, 3)), 1'($urandom), 3'($urandom), a, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit that consumes the memory controls produced in ID (MemRead, 2-bit MemWrite size code, funct3) and executes them on the data-memory bus.
- Generates word-aligned address, byte enables and lane-replicated store data.
- Runs a valid/ready request handshake and waits for load responses.
- Sign- or zero-extends load data.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, synchronous, active-high
mem_read  in  1  load request from EX/MEM register
mem_write  in  2  store size code: WRITE_IDLE=00, WRITE_BYTE=01, WRITE_HALF=10, WRITE_WORD=11
funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
addr  in  32  effective byte address from ALU
store_data  in  32  rs2 value
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  32  {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rsp_valid  in  1  read data valid
dmem_rdata  in  32  read data word
load_data  out  32  extended load result to WB
lsu_busy  out  1  stall request to hazard unit
lsu_done  out  1  one-cycle completion pulse
misalign  out  1  one-cycle misaligned-access pulse

Behaviour:
- Operation present: op = (mem_write != 00) | mem_read. If both are asserted, mem_write wins (store).
- Alignment:
  - Half-word requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte accesses are always aligned.
- Byte enables:
  - Byte: 0001 << addr[1:0]
  - Half: 0011 << {addr[1],0}
  - Word: 1111
- Store data:
  - Byte: {4{store_data[7:0]}}
  - Half: {2{store_data[15:0]}}
  - Word: store_data
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - op and aligned: latch we, addr, be, wdata, funct3, addr[1:0] into internal registers; go to REQ. lsu_busy=1 combinationally in this cycle.
  - op and misaligned: misalign=1 for this cycle, no request, stay IDLE, lsu_busy=0.
  - No op: stay IDLE.
- REQ:
  - dmem_req_valid=1. dmem_* are driven from the latched registers and held stable until dmem_req_ready.
  - On ready: store goes to DONE; load goes to WAIT_RSP. lsu_busy=1.
- WAIT_RSP:
  - dmem_req_valid=0, lsu_busy=1.
  - On dmem_rsp_valid: select the byte/half from dmem_rdata using the latched addr[1:0]; extend per funct3 (LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough); register into load_data; go to DONE.
  - dmem_rsp_valid is ignored in any state other than WAIT_RSP.
- DONE:
  - lsu_done=1, lsu_busy=0; the pipeline advances this cycle.
  - The unit does not re-launch even though the inputs still show the same instruction.
  - Next state is IDLE.
- load_data holds its value until the next load completes. Stores do not modify it.
- Undefined load funct3 (011, 110, 111) is treated as LW.
- Minimum latency:
  - Store: 2 cycles (IDLE, REQ with ready=1, then DONE).
  - Load: 3 cycles plus memory wait.
- Reset (any state, including mid-transaction):
  - Next state IDLE.
  - dmem_req_valid=0, dmem_we=0, dmem_be=0000, dmem_addr=0, dmem_wdata=0.
  - load_data=0, lsu_busy=0, lsu_done=0, misalign=0.
  - A pending response arriving after reset is discarded.
- ready asserted while valid=0 has no effect.

Decomposition:
- Shared defines file holds:
  - WRITE_IDLE/BYTE/HALF/WORD encodings
  - LB/LH/LW/LBU/LHU funct3 codes
  - LSU state encodings (2-bit)
- One combinational sub-module, load_extend: inputs rdata[31:0], byte_off[1:0], funct3[2:0]; output ext_data[31:0].

Test Plan:
- SW addr=0x104, store_data=0xDEADBEEF, ready=1 immediately -> one request with we=1, dmem_addr=0x104, be=1111, wdata=0xDEADBEEF; lsu_done pulses 2 cycles after issue.
- SB addr=0x203, data=0x000000A5, ready delayed 3 cycles -> valid held with addr=0x200, be=1000, wdata=0xA5A5A5A5 stable; busy=1 throughout; single done pulse.
- LB addr=0x101, rdata=0x0000_80FF, rsp 2 cycles after accept -> load_data=0xFFFFFF80. Same access as LBU -> load_data=0x00000080.
- LH addr=0x102, rdata=0x8001_0000 -> load_data=0xFFFF8001. LHU -> 0x00008001.
- LW addr=0x106 -> misalign pulse, no dmem_req_valid, busy=0, state stays IDLE. SH addr=0x101 gives the same response.
- rst asserted in WAIT_RSP, then rsp_valid the next cycle -> outputs at reset values, load_data stays 0, no lsu_done.
